display_bus_regfile: RTL

- Bus-slave register block directly upstream of the 7-segment scanner. Drives the scanner's 32-bit display word: 8 hex digits, digit 7 in bits [31:28].
- A CPU/bus master writes bytes into a shadow buffer over a req/ack handshake, then commits them. The visible word changes atomically, so the display never shows a half-updated value.
- A readback path and an auto-increment counter mode support demo and self-test.

---
 rtl/display_bus_regfile.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/display_bus_regfile.sv
// -----------------------------------------------------------------------------
// display_bus_regfile
// Bus-slave register block feeding the 7-segment scanner. A bus master fills a
// 32-bit shadow buffer byte by byte, then commits it. The commit replaces the
// visible display word in one step. A free-running count mode and a readback
// path are also provided.
//
// Ports:
//   clk        system clock
//   clr        synchronous active-high reset, highest priority
//   req        bus request, held by the master until it sees ack
//   we         1 = write, 0 = read (sampled at acceptance)
//   addr[2:0]  register address (sampled at acceptance)
//   wdata[7:0] write data (sampled at acceptance)
//   ack        one-cycle transfer-complete pulse
//   rdata[7:0] read data, valid in the ack cycle and held until the next ack
//   disp_data  32-bit display word, digit 7 in bits [31:28]
//   busy       high from acceptance until the handshake returns to idle
//
// Register map:
//   0..3  shadow bytes (R/W)
//   4     ctrl: bit0 COMMIT (pulse), bit1 CLEAR_SHADOW (pulse), bit2 COUNT_EN
//   5     status (RO): bit0 shadow != disp_data, bit1 COUNT_EN
//   6..7  reserved: writes are ignored, reads return 0
// -----------------------------------------------------------------------------
module display_bus_regfile #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned CNT_DIV     = 1000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [31:0] disp_data,
    output logic        busy
);

    localparam int unsigned        PRESC_W   = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CNT_DIV - 1);
    localparam logic [3:0]         WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_wait_cnt;
    logic                 r_we;
    logic [2:0]           r_addr;
    logic [7:0]           r_wdata;
    logic                 r_ack;
    logic                 r_busy;
    logic [7:0]           r_rdata;
    logic [31:0]          r_shadow;
    logic [31:0]          r_disp;
    logic                 r_count_en;
    logic [PRESC_W-1:0]   r_presc;

    logic                 w_wr;
    logic                 w_wr_byte;
    logic                 w_wr_ctrl;
    logic                 w_commit;
    logic                 w_clear;
    logic                 w_inc;

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign rdata     = r_rdata;
    assign disp_data = r_disp;

    // Register writes land on the edge that ends the ack cycle.
    assign w_wr      = (r_state == S_ACK) && r_we;
    assign w_wr_byte = w_wr && (r_addr[2] == 1'b0);
    assign w_wr_ctrl = w_wr && (r_addr == 3'd4);
    assign w_commit  = w_wr_ctrl && r_wdata[0];
    assign w_clear   = w_wr_ctrl && r_wdata[1];
    assign w_inc     = r_count_en && (r_presc == PRESC_MAX);

    // Read mux over the current register contents.
    function automatic logic [7:0] f_read(input logic [2:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            3'd0:    v = r_shadow[7:0];
            3'd1:    v = r_shadow[15:8];
            3'd2:    v = r_shadow[23:16];
            3'd3:    v = r_shadow[31:24];
            3'd4:    v = {5'b0, r_count_en, 2'b00};
            3'd5:    v = {6'b0, r_count_en, (r_shadow != r_disp)};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Handshake FSM with registered ack/busy/rdata.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 3'd0;
            r_wdata    <= 8'h00;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (req) begin
                        r_we       <= we;
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                        r_wait_cnt <= WAIT_LOAD;
                        r_busy     <= 1'b1;
                        if (WAIT_LOAD == 4'd0) begin
                            // No wait states: the latched fields are not
                            // visible yet, so read from the live address.
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            r_rdata <= f_read(addr);
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_rdata <= f_read(r_addr);
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    r_ack <= 1'b0;
                    if (!req) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow buffer: byte writes and clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_shadow <= 32'h0;
        end else if (w_clear) begin
            r_shadow <= 32'h0;
        end else if (w_wr_byte) begin
            case (r_addr[1:0])
                2'd0:    r_shadow[7:0]   <= r_wdata;
                2'd1:    r_shadow[15:8]  <= r_wdata;
                2'd2:    r_shadow[23:16] <= r_wdata;
                default: r_shadow[31:24] <= r_wdata;
            endcase
        end
    end

    // Display word: commit beats a coincident count increment.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_disp <= 32'h0;
        end else if (w_commit) begin
            r_disp <= r_shadow;
        end else if (w_inc) begin
            r_disp <= r_disp + 32'd1;
        end
    end

    // COUNT_EN is sticky: every ctrl write reloads it from bit 2.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_count_en <= r_wdata[2];
        end
    end

    // Prescaler runs only in count mode and parks at 0 otherwise.
    always_ff @(posedge clk) begin
        if (clr || !r_count_en) begin
            r_presc <= '0;
        end else if (w_inc) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

endmodule
